// File: rtl/paddle_cap_emu_pkg.sv
// Shared types for the paddle capacitor emulator: source select encoding and
// the 8-bit position type, plus the analog-to-offset-binary helper.
package pkg_paddle;

    typedef enum logic [1:0] {
        SRC_BTN   = 2'd0,
        SRC_ANA_X = 2'd1,
        SRC_ANA_Y = 2'd2,
        SRC_PAD   = 2'd3
    } src_e;

    localparam int POS_W = 8;
    typedef logic [POS_W-1:0] pos_t;

    // Signed stick value -> 0..255 with centre at 128.
    function automatic pos_t ana_to_pos(input logic [7:0] a);
        return {~a[7], a[6:0]};
    endfunction

endpackage

// File: rtl/paddle_cap_emu_chan.sv
// One paddle channel: source mux, button-driven position with clamping, and the
// per-field charge-time down-counter.
module paddle_chan
    import pkg_paddle::*;
#(
    parameter pos_t POS_RESET = 8'd128
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        vs_rise,
    input  logic        hs_rise,
    input  pos_t        step,
    input  src_e        src,
    input  logic        inv,
    input  logic        up,
    input  logic        dn,
    input  logic [15:0] ana,
    input  pos_t        pad,
    output pos_t        pos,
    output logic        cap_zero
);

    pos_t       cap;
    pos_t       src_val;
    pos_t       pos_next;
    logic [8:0] sum;

    always_comb begin
        src_val = pos;
        case (src)
            SRC_ANA_X: src_val = ana_to_pos(ana[15:8]);
            SRC_ANA_Y: src_val = ana_to_pos(ana[7:0]);
            SRC_PAD:   src_val = pad;
            default:   src_val = pos;
        endcase
    end

    always_comb begin
        sum      = {1'b0, pos} + {1'b0, step};
        pos_next = pos;
        if (up && !dn) begin
            pos_next = (pos < step) ? '0 : pos - step;
        end else if (dn && !up) begin
            pos_next = sum[8] ? 8'hFF : sum[7:0];
        end
    end

    // Field start reloads the counter; a coincident hsync is deliberately dropped.
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            pos <= POS_RESET;
            cap <= '0;
        end else if (vs_rise) begin
            // NOTE: non-blocking so the load below sees pos from before this field's move.
            cap <= src_val ^ {POS_W{inv}};
            if (src == SRC_BTN) begin
                pos <= pos_next;
            end
        end else if (hs_rise && cap != '0) begin
            cap <= cap - 8'd1;
        end
    end

    assign cap_zero = (cap == '0);

endmodule

// File: rtl/paddle_cap_emu.sv
// Paddle capacitor emulator top: sync edge detection, two channels, and the
// practice-mode mirror of the left paddle onto the right.
module paddle_cap_emu
    import pkg_paddle::*;
#(
    parameter int STEP_SLOW = 5,
    parameter int STEP_FAST = 8,
    parameter int POS_RESET = 128
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs,
    input  logic        vs,
    input  logic        speed,
    input  logic        practice,
    input  logic [1:0]  p1_src,
    input  logic [1:0]  p2_src,
    input  logic        p1_inv,
    input  logic        p2_inv,
    input  logic        p1_up,
    input  logic        p1_dn,
    input  logic        p2_up,
    input  logic        p2_dn,
    input  logic [15:0] ana0,
    input  logic [15:0] ana1,
    input  logic [7:0]  pad0,
    input  logic [7:0]  pad1,
    output logic [7:0]  p1_pos,
    output logic [7:0]  p2_pos,
    output logic        lp_in,
    output logic        rp_in
);

    logic hs_d;
    logic vs_d;
    logic hs_rise;
    logic vs_rise;
    logic cap1_zero;
    logic cap2_zero;
    pos_t step;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            hs_d <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            hs_d <= hs;
            vs_d <= vs;
        end
    end

    assign hs_rise = hs & ~hs_d;
    assign vs_rise = vs & ~vs_d;
    assign step    = speed ? pos_t'(STEP_FAST) : pos_t'(STEP_SLOW);

    paddle_chan #(.POS_RESET(pos_t'(POS_RESET))) u_chan1 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vs_rise  (vs_rise),
        .hs_rise  (hs_rise),
        .step     (step),
        .src      (src_e'(p1_src)),
        .inv      (p1_inv),
        .up       (p1_up),
        .dn       (p1_dn),
        .ana      (ana0),
        .pad      (pad0),
        .pos      (p1_pos),
        .cap_zero (cap1_zero)
    );

    paddle_chan #(.POS_RESET(pos_t'(POS_RESET))) u_chan2 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .vs_rise  (vs_rise),
        .hs_rise  (hs_rise),
        .step     (step),
        .src      (src_e'(p2_src)),
        .inv      (p2_inv),
        .up       (p2_up),
        .dn       (p2_dn),
        .ana      (ana1),
        .pad      (pad1),
        .pos      (p2_pos),
        .cap_zero (cap2_zero)
    );

    assign lp_in = cap1_zero;
    assign rp_in = practice ? cap1_zero : cap2_zero;

endmodule

// File: tb/tb_paddle_cap_emu.sv
// Bench for paddle_cap_emu: directed steps plus randomized fields, checked
// against an arithmetic model of positions and per-field charge counts.
module tb_paddle_cap_emu;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        hs, vs, speed, practice;
    logic [1:0]  p1_src, p2_src;
    logic        p1_inv, p2_inv, p1_up, p1_dn, p2_up, p2_dn;
    logic [15:0] ana0, ana1;
    logic [7:0]  pad0, pad1;
    logic [7:0]  p1_pos, p2_pos;
    logic        lp_in, rp_in;

    int n_cmp = 0;
    int n_err = 0;
    int m_pos [2];
    int m_cap [2];

    paddle_cap_emu dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .hs       (hs),
        .vs       (vs),
        .speed    (speed),
        .practice (practice),
        .p1_src   (p1_src),
        .p2_src   (p2_src),
        .p1_inv   (p1_inv),
        .p2_inv   (p2_inv),
        .p1_up    (p1_up),
        .p1_dn    (p1_dn),
        .p2_up    (p2_up),
        .p2_dn    (p2_dn),
        .ana0     (ana0),
        .ana1     (ana1),
        .pad0     (pad0),
        .pad1     (pad1),
        .p1_pos   (p1_pos),
        .p2_pos   (p2_pos),
        .lp_in    (lp_in),
        .rp_in    (rp_in)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int stick(input logic [7:0] raw);
        logic signed [7:0] s;
        s = raw;
        return int'(s) + 128;
    endfunction

    function automatic int clamp255(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    // Value the chip should see at field start, before any button move.
    function automatic int source_value(input int ch);
        logic [1:0]  src;
        logic [15:0] a;
        logic [7:0]  p;
        int          v;
        src = (ch == 0) ? p1_src : p2_src;
        a   = (ch == 0) ? ana0 : ana1;
        p   = (ch == 0) ? pad0 : pad1;
        case (src)
            2'd1:    v = stick(a[15:8]);
            2'd2:    v = stick(a[7:0]);
            2'd3:    v = int'(p);
            default: v = m_pos[ch];
        endcase
        if (((ch == 0) ? p1_inv : p2_inv)) v = 255 - v;
        return v;
    endfunction

    task automatic model_reset();
        m_pos = '{128, 128};
        m_cap = '{0, 0};
    endtask

    task automatic model_field();
        int st;
        logic u, d;
        st = speed ? 8 : 5;
        for (int ch = 0; ch < 2; ch++) begin
            m_cap[ch] = source_value(ch);
            u = (ch == 0) ? p1_up : p2_up;
            d = (ch == 0) ? p1_dn : p2_dn;
            if (((ch == 0) ? p1_src : p2_src) == 2'd0 && u != d)
                m_pos[ch] = clamp255(m_pos[ch] + (u ? -st : st));
        end
    endtask

    task automatic model_line();
        for (int ch = 0; ch < 2; ch++)
            if (m_cap[ch] > 0) m_cap[ch]--;
    endtask

    task automatic check_outs(input string tag);
        logic lp_exp;
        lp_exp = (m_cap[0] == 0);
        chk({tag, ".p1_pos"}, p1_pos, m_pos[0]);
        chk({tag, ".p2_pos"}, p2_pos, m_pos[1]);
        chk({tag, ".lp_in"}, lp_in, lp_exp);
        chk({tag, ".rp_in"}, rp_in, practice ? lp_exp : (m_cap[1] == 0));
    endtask

    task automatic clk_edge();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic vs_pulse(input string tag);
        vs = 1'b1;
        clk_edge();
        model_field();
        check_outs(tag);
        vs = 1'b0;
        clk_edge();
    endtask

    task automatic hs_pulse(input string tag);
        hs = 1'b1;
        clk_edge();
        model_line();
        check_outs(tag);
        hs = 1'b0;
        clk_edge();
    endtask

    task automatic both_pulse(input string tag);
        hs = 1'b1;
        vs = 1'b1;
        clk_edge();
        model_field();
        check_outs(tag);
        hs = 1'b0;
        vs = 1'b0;
        clk_edge();
    endtask

    task automatic set_buttons(input logic u1, input logic d1, input logic u2, input logic d2);
        p1_up = u1; p1_dn = d1; p2_up = u2; p2_dn = d2;
    endtask

    initial begin
        reset = 1'b0; hs = 1'b0; vs = 1'b0; speed = 1'b0; practice = 1'b0;
        p1_src = 2'd0; p2_src = 2'd0; p1_inv = 1'b0; p2_inv = 1'b0;
        set_buttons(0, 0, 0, 0);
        ana0 = '0; ana1 = '0; pad0 = '0; pad1 = '0;
        model_reset();
        repeat (3) clk_edge();
        reset = 1'b1;
        repeat (2) clk_edge();

        // Reset state
        chk("rst.p1_pos", p1_pos, 128);
        chk("rst.p2_pos", p2_pos, 128);
        chk("rst.lp_in", lp_in, 1);
        chk("rst.rp_in", rp_in, 1);

        // Up clamp at 0, slow step
        set_buttons(1, 0, 0, 0);
        for (int k = 1; k <= 30; k++) begin
            vs_pulse("up_slow");
            chk("up_slow.const", p1_pos, (128 - 5 * k < 0) ? 0 : 128 - 5 * k);
        end

        // Down to 250 slow, then fast up to 255 clamp
        set_buttons(0, 1, 0, 0);
        repeat (50) vs_pulse("dn_slow");
        chk("dn_slow.250", p1_pos, 250);
        speed = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            vs_pulse("dn_fast");
            chk("dn_fast.255", p1_pos, 255);
        end

        // Bring p1 to 100 and time one field of hsyncs
        speed = 1'b0;
        set_buttons(1, 0, 0, 0);
        repeat (31) vs_pulse("to100");
        chk("to100.pos", p1_pos, 100);
        set_buttons(0, 0, 0, 0);
        vs_pulse("cap100.load");
        chk("cap100.lp_low", lp_in, 0);
        for (int i = 1; i <= 120; i++) begin
            hs_pulse("cap100");
            chk("cap100.edge", lp_in, (i >= 100) ? 1 : 0);
        end

        // Analog sources and inversion on p2
        p2_src = 2'd1; ana1 = 16'h8000;
        vs_pulse("ana_x_min");
        chk("ana_x_min.rp", rp_in, 1);
        p2_inv = 1'b1;
        vs_pulse("ana_x_inv");
        chk("ana_x_inv.rp", rp_in, 0);
        p2_inv = 1'b0; p2_src = 2'd2; ana1 = 16'h007F;
        vs_pulse("ana_y_max");
        chk("ana_y_max.rp", rp_in, 0);
        p2_src = 2'd0;
        vs_pulse("p2_back_btn");
        chk("p2_back_btn.pos", p2_pos, 128);

        // Coincident hs/vs: load wins; both buttons hold
        set_buttons(1, 0, 0, 0);
        repeat (18) vs_pulse("to10");
        set_buttons(1, 1, 0, 0);
        both_pulse("coinc");
        chk("coinc.pos", p1_pos, 10);
        for (int i = 1; i <= 10; i++) hs_pulse("coinc.cnt");
        chk("coinc.10th", lp_in, 1);
        set_buttons(0, 0, 0, 0);

        // Randomized fields with mid-field input changes
        for (int f = 0; f < 8; f++) begin
            int n;
            p1_src = 2'($urandom); p2_src = 2'($urandom);
            p1_inv = 1'($urandom); p2_inv = 1'($urandom);
            set_buttons(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            speed = 1'($urandom);
            ana0 = 16'($urandom); ana1 = 16'($urandom);
            pad0 = 8'($urandom); pad1 = 8'($urandom);
            vs_pulse("rnd.vs");
            n = $urandom_range(20, 260);
            for (int i = 0; i < n; i++) begin
                if (i == n / 2) begin
                    p1_src = 2'($urandom); p2_inv = 1'($urandom);
                    set_buttons(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
                end
                hs_pulse("rnd.hs");
            end
        end

        // Practice: p1 at 50, p2 at 200, rp mirrors lp
        p1_src = 2'd0; p2_src = 2'd0; p1_inv = 1'b0; p2_inv = 1'b0;
        speed = 1'b1;
        set_buttons(1, 0, 0, 1);
        repeat (32) vs_pulse("prac.clamp");
        speed = 1'b0;
        set_buttons(0, 1, 1, 0);
        repeat (10) vs_pulse("prac.move");
        set_buttons(0, 0, 1, 0);
        vs_pulse("prac.move2");
        set_buttons(0, 0, 0, 0);
        chk("prac.p1_50", p1_pos, 50);
        chk("prac.p2_200", p2_pos, 200);
        practice = 1'b1;
        vs_pulse("prac.load");
        for (int i = 0; i < 60; i++) begin
            hs_pulse("prac.hs");
            chk("prac.mirror", rp_in, lp_in);
        end

        // Asynchronous reset mid-count
        vs_pulse("mid.load");
        repeat (10) hs_pulse("mid.hs");
        chk("mid.before", lp_in, 0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outs("mid.async");
        clk_edge();
        check_outs("mid.held");
        reset = 1'b1;
        clk_edge();
        practice = 1'b0;
        check_outs("mid.release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
